// File: rtl/acc_pkg.sv
// Shared constants, sizing helpers and enums for the accelerator DMA initiator.
// No logic; combinational helpers evaluated at elaboration only.
package acc_pkg;

  localparam logic [31:0] ADDR_WRITE = 32'h0110_0000;
  localparam logic [31:0] ADDR_READ  = 32'h0130_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SRC,
    ST_WR_ACC,
    ST_RD_RES,
    ST_WR_DST,
    ST_DONE
  } state_t;

  typedef enum logic {
    ACC_RD,
    ACC_WR
  } access_t;

  function automatic int w_in(input int r, input int s, input int iw);
    return iw * (r + r * s) / 32;
  endfunction

  function automatic int w_out(input int s, input int rw);
    return rw * s / 32;
  endfunction

endpackage

// File: rtl/acc_bus_port.sv
// Single-transaction initiator on mem_valid/mem_ready: launches one access per req,
// holds it until mem_ready or TIMEOUT wait cycles, then forces one idle gap cycle.
module acc_bus_port #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        tout,
  output logic [31:0] rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  assign ack   = mem_valid && mem_ready;
  assign tout  = mem_valid && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));
  assign rdata = mem_rdata;

  // A request is only taken while mem_valid is low, so the cycle after a
  // completed or aborted access is always an idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wait_cnt  <= '0;
    end else if (mem_valid) begin
      if (ack || tout) begin
        mem_valid <= 1'b0;
        wait_cnt  <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else if (req) begin
      mem_valid <= 1'b1;
      mem_addr  <= addr;
      mem_wdata <= wr ? wdata : '0;
      mem_wstrb <= wr ? 4'hF : 4'h0;
    end
  end

endmodule

// File: rtl/acc_dma.sv
// Copies one packed input chunk RAM->accelerator and the result vector back to RAM.
// Each access takes 2 + wait cycles plus one gap; start is ignored while busy.
module acc_dma
  import acc_pkg::*;
#(
  parameter int R            = 4,
  parameter int S            = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dst_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int W_IN  = w_in(R, S, INPUT_WIDTH);
  localparam int W_OUT = w_out(S, RESULT_WIDTH);

  generate
    if (W_IN * 32 != INPUT_WIDTH * (R + R * S) || W_OUT * 32 != RESULT_WIDTH * S) begin : g_bad_geometry
      $error("acc_dma: chunk geometry does not pack into whole 32-bit words");
    end
  endgenerate

  state_t      state;
  logic [7:0]  idx;
  logic [31:0] src, dst, hold;
  logic [31:0] off;
  logic        req, ack, tout;
  access_t     kind;
  logic [31:0] req_addr, rdata;

  assign off = {22'd0, idx, 2'b00};

  // The first read is issued on the same edge that accepts start, so in IDLE
  // the address comes straight from the port rather than the latched copy.
  always_comb begin
    req      = 1'b0;
    kind     = ACC_RD;
    req_addr = '0;
    case (state)
      ST_IDLE:   begin req = start;      req_addr = src_addr & ~32'h3; end
      ST_RD_SRC: begin req = !mem_valid; req_addr = src + off; end
      ST_WR_ACC: begin req = !mem_valid; req_addr = ADDR_WRITE + off; kind = ACC_WR; end
      ST_RD_RES: begin req = !mem_valid; req_addr = ADDR_READ + off; end
      ST_WR_DST: begin req = !mem_valid; req_addr = dst + off; kind = ACC_WR; end
      default:   ;
    endcase
  end

  acc_bus_port #(.TIMEOUT(TIMEOUT)) u_port (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr        (kind == ACC_WR),
    .addr      (req_addr),
    .wdata     (hold),
    .ack       (ack),
    .tout      (tout),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      src   <= '0;
      dst   <= '0;
      hold  <= '0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            src   <= src_addr & ~32'h3;
            dst   <= dst_addr & ~32'h3;
            idx   <= '0;
            error <= 1'b0;
            busy  <= 1'b1;
            state <= ST_RD_SRC;
          end
        end
        ST_RD_SRC, ST_WR_ACC, ST_RD_RES, ST_WR_DST: begin
          if (tout) begin
            // Abort: done stays low here so DONE first spends one gap cycle.
            error <= 1'b1;
            idx   <= '0;
            state <= ST_DONE;
          end else if (ack) begin
            case (state)
              ST_RD_SRC: begin hold <= rdata; state <= ST_WR_ACC; end
              ST_WR_ACC: begin
                if (idx == 8'(W_IN - 1)) begin
                  idx   <= '0;
                  state <= ST_RD_RES;
                end else begin
                  idx   <= idx + 8'd1;
                  state <= ST_RD_SRC;
                end
              end
              ST_RD_RES: begin hold <= rdata; state <= ST_WR_DST; end
              default: begin
                if (idx == 8'(W_OUT - 1)) begin
                  idx   <= '0;
                  done  <= 1'b1;
                  state <= ST_DONE;
                end else begin
                  idx   <= idx + 8'd1;
                  state <= ST_RD_RES;
                end
              end
            endcase
          end
        end
        ST_DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_dma.sv
// Bench for acc_dma: RAM + accelerator responder, bus monitor, and directed and
// randomized commands checked against a word/element-level reference model.
module tb_acc_dma;

  localparam logic [31:0] AW = 32'h0110_0000;
  localparam logic [31:0] AR = 32'h0130_0000;
  localparam int WI = 5;
  localparam int WO = 2;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] src_addr, dst_addr;
  logic        busy, done, error;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  acc_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [logic [31:0]];
  logic [31:0] srcw [WI];
  logic [31:0] accw [WI];
  int          nwait = 0;
  int          wcnt = 0;
  bit          stale = 1'b0;
  logic [31:0] inj_s = 32'h0, inj_d = 32'h0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] gap;
  } acc_t;
  acc_t trace [$];

  // Row vector A (R bytes) then column-major B; result c = sum_r A[r]*B[r][c].
  function automatic logic [31:0] res_word(input logic [31:0] w [WI], input int j);
    logic [7:0]  e [WI*4];
    logic [15:0] r [4];
    for (int k = 0; k < WI*4; k++) e[k] = w[k/4][8*(k%4) +: 8];
    for (int c = 0; c < 4; c++) begin
      r[c] = 16'd0;
      for (int i = 0; i < 4; i++) r[c] = r[c] + 16'(e[i]) * 16'(e[4 + 4*c + i]);
    end
    return {r[2*j+1], r[2*j]};
  endfunction

  function automatic logic [31:0] ramrd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'hxxxx_xxxx;
  endfunction

  // Responder: ready one cycle after the request plus nwait; 0xDEAD.... never answers.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end else begin
      mem_ready <= stale && mem_valid && mem_ready;
      if (mem_valid && !mem_ready && mem_addr[31:16] != 16'hDEAD) begin
        if (wcnt < nwait) begin
          wcnt <= wcnt + 1;
        end else begin
          wcnt      <= 0;
          mem_ready <= 1'b1;
          if (mem_wstrb == 4'hF) begin
            ram[mem_addr] = mem_wdata;
          end else if (mem_addr >= AR && mem_addr < AR + 4*WO) begin
            for (int i = 0; i < WI; i++) accw[i] = ram.exists(AW + 4*i) ? ram[AW + 4*i] : 32'h0;
            mem_rdata <= res_word(accw, int'((mem_addr - AR) / 4));
          end else begin
            mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : 32'h0;
          end
        end
      end
    end
  end

  int          low_run = 0, cur_gap = 0, hi_run = 0, last_hi = 0, stab_bad = 0;
  logic        pv = 1'b0;
  logic [67:0] pbus = '0;

  always @(negedge clk) begin
    if (mem_valid) begin
      if (!pv) begin
        cur_gap = low_run;
        hi_run  = 0;
      end else if ({mem_addr, mem_wdata, mem_wstrb} !== pbus) begin
        stab_bad++;
      end
      hi_run++;
      if (mem_ready) trace.push_back('{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb, gap: cur_gap});
    end else begin
      if (pv) begin
        last_hi = hi_run;
        low_run = 0;
      end
      low_run++;
    end
    pv   = mem_valid;
    pbus = {mem_addr, mem_wdata, mem_wstrb};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_error"},     error, 0);
  endtask

  task automatic set_basic();
    srcw[0] = 32'h0403_0201;
    srcw[1] = 32'h0101_0101;
    srcw[2] = 32'h0202_0202;
    srcw[3] = 32'h0303_0303;
    srcw[4] = 32'h0404_0404;
  endtask

  // Called at a negedge in IDLE; returns done cycle (start edge = edge 0).
  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int inj,
                         output int dc, output int bc, output logic ba, output logic er, output logic e1);
    dc = -1; bc = 0; ba = 1'bx; er = 1'bx; e1 = 1'bx;
    trace.delete();
    start = 1'b1; src_addr = s; dst_addr = d;
    @(negedge clk);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom;
    for (int c = 1; c < 2000; c++) begin
      if (c == 1) e1 = error;
      if (busy) bc++;
      if (done) begin
        dc = c; er = error;
        @(negedge clk);
        ba = busy;
        break;
      end
      start = (c == inj);
      if (c == inj) begin src_addr = inj_s; dst_addr = inj_d; end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_trace(input logic [31:0] sm, input logic [31:0] dm, input int n);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    int          i;
    chk("trace_len", trace.size(), n);
    for (int k = 0; k < n && k < trace.size(); k++) begin
      ed = 32'h0;
      if (k < 2*WI) begin
        i  = k / 2;
        ea = (k % 2 == 0) ? sm + 4*i : AW + 4*i;
        ed = srcw[i];
      end else begin
        i  = (k - 2*WI) / 2;
        ea = (k % 2 == 0) ? AR + 4*i : dm + 4*i;
        ed = res_word(srcw, i);
      end
      es = (k % 2 == 0) ? 4'h0 : 4'hF;
      chk($sformatf("trace%0d_addr", k), trace[k].addr, ea);
      chk($sformatf("trace%0d_wstrb", k), trace[k].wstrb, es);
      if (k % 2 == 1) chk($sformatf("trace%0d_wdata", k), trace[k].wdata, ed);
      if (k > 0) chk($sformatf("trace%0d_gap", k), trace[k].gap, 1);
    end
  endtask

  task automatic do_cmd(input string tag, input logic [31:0] s, input logic [31:0] d, input int w, input int inj);
    int          dc, bc;
    logic        ba, er, e1;
    logic [31:0] sm, dm;
    sm = s & ~32'h3;
    dm = d & ~32'h3;
    for (int i = 0; i < WI; i++) ram[sm + 4*i] = srcw[i];
    for (int j = 0; j < WO; j++) ram.delete(dm + 4*j);
    nwait = w;
    run_cmd(s, d, inj, dc, bc, ba, er, e1);
    chk({tag, "_done_cycle"}, dc, 14 * (3 + w));
    chk({tag, "_busy_cycles"}, bc, 14 * (3 + w));
    chk({tag, "_busy_after"}, ba, 0);
    chk({tag, "_error_at_start"}, e1, 0);
    chk({tag, "_error"}, er, 0);
    for (int j = 0; j < WO; j++) chk($sformatf("%s_res%0d", tag, j), ramrd(dm + 4*j), res_word(srcw, j));
    check_trace(sm, dm, 14);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc, bc;
    logic        ba, er, e1, hit;
    logic [31:0] s, d;

    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
    repeat (3) @(negedge clk);
    zero_outs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic chunk, zero-wait responder.
    set_basic();
    do_cmd("basic", 32'h1000, 32'h2000, 0, 0);
    chk("basic_ram2000", ramrd(32'h2000), 32'h0014_000A);
    chk("basic_ram2004", ramrd(32'h2004), 32'h0028_001E);

    // Three wait cycles on every access.
    do_cmd("wait3", 32'h1000, 32'h2000, 3, 0);
    chk("wait3_ram2000", ramrd(32'h2000), 32'h0014_000A);

    // Random chunks, random address low bits, waits and stale-ready responder.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < WI; i++) srcw[i] = $urandom;
      s = 32'h0001_0000 + ($urandom_range(0, 255) << 5) + $urandom_range(0, 3);
      d = 32'h0004_0000 + ($urandom_range(0, 255) << 5) + $urandom_range(0, 3);
      stale = 1'($urandom_range(0, 1));
      do_cmd($sformatf("rand%0d", r), s, d, $urandom_range(0, 2), 0);
    end
    stale = 1'b0;

    // Start while busy must not disturb the running command.
    for (int i = 0; i < WI; i++) srcw[i] = $urandom;
    inj_s = 32'h0005_0000;
    inj_d = 32'h0006_0000;
    ram.delete(inj_d);
    do_cmd("startbusy", 32'h0003_0100, 32'h0003_0800, 0, 10);
    chk("startbusy_newdst_untouched", ram.exists(inj_d), 0);

    // Timeout on the first destination write (access 12).
    set_basic();
    nwait = 0;
    for (int i = 0; i < WI; i++) ram[32'h1000 + 4*i] = srcw[i];
    run_cmd(32'h1000, 32'hDEAD_0000, 0, dc, bc, ba, er, e1);
    chk("tout_done_cycle", dc, 11*3 + 255 + 2);
    chk("tout_busy_cycles", bc, 11*3 + 255 + 2);
    chk("tout_error", er, 1);
    chk("tout_valid_high", last_hi, 255);
    chk("tout_error_held", error, 1);
    check_trace(32'h1000, 32'hDEAD_0000, 11);
    do_cmd("after_tout", 32'h1000, 32'h2400, 0, 0);

    // Reset during WR_ACC, then a clean command.
    set_basic();
    trace.delete();
    start = 1'b1; src_addr = 32'h1000; dst_addr = 32'h3000;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (mem_valid && mem_wstrb == 4'hF) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    chk("rst_reached_wr_acc", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    zero_outs("midrst");
    rst = 1'b0;
    @(negedge clk);
    do_cmd("post_rst", 32'h1000, 32'h3000, 0, 0);
    chk("post_rst_ram3000", ramrd(32'h3000), 32'h0014_000A);
    chk("post_rst_ram3004", ramrd(32'h3004), 32'h0028_001E);

    chk("bus_stable_while_waiting", stab_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
